subbytes_seq: RTL
=================

# subbytes_seq

Byte-serial AES SubBytes stage that sits directly upstream of the existing `sbox` and drives it. The stage accepts a 128-bit AES state over a valid/ready handshake and feeds one byte per cycle into the `sbox` instance. It collects the substituted bytes back into a 128-bit result and presents that result over a second valid/ready handshake. It is the first sequential wrapper that turns the standalone `sbox` into a usable round component.

## Interface
Parameters:
- `SBOX_LAT`, default 1: cycles from the `sbox` `in` change to valid `out`. 1 is the registered `sbox`; 0 is a combinational variant.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the block can accept a state.
- `in_data`  in  128  input state. Byte 0 is `[127:120]` and byte 15 is `[7:0]`.
- `out_valid`  out  1  `out_data` holds a complete result.
- `out_ready`  in  1  the consumer accepts `out_data`.
- `out_data`  out  128  SubBytes(state), using the same byte ordering as `in_data`.
- `key_data`  in  128  round key. This port exists only with `SUBBYTES_ADDKEY_EN`.

## Operation
- FSM states:
  - IDLE → RUN on `in_valid && in_ready`. `in_data` is latched into the state register.
  - RUN → DONE when the last byte (index 15) is captured.
  - DONE → IDLE on `out_valid && out_ready`.
- `in_ready` = (state == IDLE), combinational from the state only.
- `out_valid` = (state == DONE).
- Issue counter `iss` (0..15): in RUN, byte `iss` of the latched state drives the `sbox` input. `iss` increments every cycle and saturates at 15.
- Capture counter `cap` (0..15): trails `iss` by `SBOX_LAT` cycles. The `sbox` output is written into result byte `cap`.
- Capture is gated by a `SBOX_LAT`-deep valid shift register, so no garbage bytes are captured at the start of RUN.
- When the block is not issuing, the `sbox` input is driven to 0x00.
- `out_data` is held stable throughout DONE. It changes only when a new block completes.
- In RUN and DONE, `in_valid` is ignored and `in_data` may change freely.
- Reset at any time:
  - Aborts the operation and returns the FSM to IDLE.
  - Clears both counters, the valid shift register, the state register and the result register.
- No back-to-back overlap: the next state is accepted only after the DONE handshake.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0. The `sbox` input is 0x00.
- Let E0 be the accepting edge.
  - Byte i drives the `sbox` input in the cycle after edge E(i).
  - Byte i is captured at edge E(i+1+`SBOX_LAT`).
  - `out_valid` rises after edge E(16+`SBOX_LAT`), which is E17 at the default setting.
- Output handshake completes at edge Ed, where `out_valid && out_ready`. `in_ready` is 1 from Ed onward, so the next accept is at Ed+1 at the earliest.
- Throughput: one block per 18+`SBOX_LAT` cycles with `out_ready` tied high.
- With `out_ready` low, DONE persists indefinitely with no change to the outputs.

## Configuration
- `SUBBYTES_ADDKEY_EN` defined:
  - The `key_data` port exists and is latched together with `in_data`.
  - Each issued byte is `state_byte ^ key_byte` (AddRoundKey fused before SubBytes).
  - Timing is unchanged.
- `SUBBYTES_ADDKEY_EN` not defined:
  - The `key_data` port is absent and bytes are issued unmodified.

## Structure
- Shared package `subbytes_pkg`:
  - Constants `NBYTES`=16, `BYTE_W`=8, `STATE_W`=128.
  - FSM state encoding IDLE/RUN/DONE.
  - Byte-index function mapping index i to bit slice `[127-8i -: 8]`.
- One sub-module: the existing `sbox` (ports `in`, `out`, `clk`), instantiated once.
- Counters, FSM and registers stay inside `subbytes_seq`.

## Test plan
- All-zero state, `out_ready`=1 → `out_data` = 0x63 repeated 16 times. `out_valid` rises exactly 17 edges after accept.
- `in_data`=00112233445566778899aabbccddeeff → `out_data`=638293c31bfc33f5c4eeacea4bc12816.
- Hold `out_ready`=0 for 10 cycles after `out_valid` → outputs are stable and `in_ready`=0. Raising `out_ready` gives `in_ready`=1 on the next cycle.
- Toggle `in_valid` and `in_data` (e.g. to all 0xff) during RUN → the result still matches the originally accepted state, and no extra block is produced.
- Assert `rst` at cycle 8 of RUN → immediately `out_valid`=0, `out_data`=0, `in_ready`=1. The next block (all 0xff) yields 0x16 repeated 16 times.
- With `SUBBYTES_ADDKEY_EN` and `key_data`=`in_data`=00112233445566778899aabbccddeeff → `out_data` = 0x63 repeated 16 times.

Source files
------------

// File: rtl/subbytes_pkg.sv
// Shared constants, FSM encoding and byte helpers for the byte-serial SubBytes stage.
package subbytes_pkg;

   localparam int unsigned NBYTES  = 16;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned STATE_W = 128;

   // Mask over byte 0, i.e. bits [127:120]; shifted right to reach byte i.
   localparam logic [STATE_W-1:0] BYTE0_MASK = {8'hFF, 120'h0};

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Byte i of a state is bit slice [127-8i -: 8].
   function automatic logic [BYTE_W-1:0] state_byte(input logic [STATE_W-1:0] s,
                                                    input logic [3:0]         i);
      logic [STATE_W-1:0] t;
      t = s << (BYTE_W * i);
      return t[STATE_W-1 -: BYTE_W];
   endfunction

endpackage

// File: rtl/subbytes_seq_sbox.sv
// AES S-box: GF(2^8) inverse followed by the affine map; LAT output register stages (0 = combinational).
module sbox #(
   parameter int unsigned LAT = 1
) (
   input  logic       clk,
   input  logic [7:0] in,
   output logic [7:0] out
);

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] x, y, p;
      x = a;
      y = b;
      p = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse (and maps 0 to 0).
   function automatic logic [7:0] sub_byte(input logic [7:0] x);
      logic [7:0] r, p;
      r = 8'h01;
      p = x;
      for (int unsigned k = 1; k < 8; k++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   logic [7:0] w_sub;
   assign w_sub = sub_byte(in);

   if (LAT == 0) begin : g_comb
      assign out = w_sub;
   end else begin : g_reg
      logic [7:0] r_pipe [LAT];
      always_ff @(posedge clk) begin
         r_pipe[0] <= w_sub;
         for (int unsigned k = 1; k < LAT; k++) r_pipe[k] <= r_pipe[k-1];
      end
      assign out = r_pipe[LAT-1];
   end

endmodule

// File: rtl/subbytes_seq.sv
// Byte-serial AES SubBytes stage driving one sbox instance over valid/ready handshakes.
// Define SUBBYTES_ADDKEY_EN to add key_data and fuse AddRoundKey before each substitution.
module subbytes_seq
   import subbytes_pkg::*;
#(
   parameter int unsigned SBOX_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_data
`ifdef SUBBYTES_ADDKEY_EN
   ,
   input  logic [STATE_W-1:0] key_data
`endif
);

   state_t             r_state, w_state_next;
   logic [STATE_W-1:0] r_data, r_acc, r_out, w_acc_next;
   logic [3:0]         r_iss, r_cap;
   logic               r_issuing, w_accept, w_cap_en;
   logic [BYTE_W-1:0]  w_byte, w_sbox_in, w_sbox_out;

`ifdef SUBBYTES_ADDKEY_EN
   logic [STATE_W-1:0] r_key;
   assign w_byte = state_byte(r_data, r_iss) ^ state_byte(r_key, r_iss);
`else
   assign w_byte = state_byte(r_data, r_iss);
`endif

   assign w_accept  = (r_state == IDLE) && in_valid;
   assign w_sbox_in = r_issuing ? w_byte : '0;

   sbox #(.LAT(SBOX_LAT)) u_sbox (
      .clk (clk),
      .in  (w_sbox_in),
      .out (w_sbox_out)
   );

   // Capture enable trails issue by SBOX_LAT cycles so stale sbox output is never stored.
   if (SBOX_LAT == 0) begin : g_vld_comb
      assign w_cap_en = r_issuing;
   end else begin : g_vld_pipe
      logic [SBOX_LAT-1:0] r_vld;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) r_vld <= '0;
         else     r_vld <= SBOX_LAT'({r_vld, r_issuing});
      end
      assign w_cap_en = r_vld[SBOX_LAT-1];
   end

   assign w_acc_next = (r_acc & ~(BYTE0_MASK >> (BYTE_W * r_cap)))
                     | ({w_sbox_out, {(STATE_W-BYTE_W){1'b0}}} >> (BYTE_W * r_cap));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = RUN;
         end
         RUN:  if (w_cap_en && (r_cap == 4'd15)) w_state_next = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // r_out is only updated with the final byte so out_data stays put while the next block runs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data    <= '0;
         r_acc     <= '0;
         r_out     <= '0;
         r_iss     <= '0;
         r_cap     <= '0;
         r_issuing <= 1'b0;
`ifdef SUBBYTES_ADDKEY_EN
         r_key     <= '0;
`endif
      end else if (w_accept) begin
         r_data    <= in_data;
         r_iss     <= '0;
         r_cap     <= '0;
         r_issuing <= 1'b1;
`ifdef SUBBYTES_ADDKEY_EN
         r_key     <= key_data;
`endif
      end else begin
         if (r_issuing) begin
            if (r_iss == 4'd15) r_issuing <= 1'b0;
            else                r_iss     <= r_iss + 4'd1;
         end
         if (w_cap_en) begin
            r_acc <= w_acc_next;
            if (r_cap == 4'd15) r_out <= w_acc_next;
            else                r_cap <= r_cap + 4'd1;
         end
      end
   end

   assign out_data = r_out;

endmodule
